// File: rtl/isp_dgain_ctrl_if.sv
// Verdict/override inputs and gain-index outputs of the digital-gain controller.
// ae_valid is a one-cycle strobe with no back-pressure: the controller accepts a verdict on every cycle it is high.
interface isp_dgain_ctrl_if #(
    parameter int DGAIN_ARRAY_BITS = 7
);
    logic                        ae_valid;
    logic [1:0]                  ae_response;
    logic                        manual_en;
    logic [DGAIN_ARRAY_BITS:0]   manual_index;
    logic [DGAIN_ARRAY_BITS-1:0] dgain_index;
    logic                        dgain_update;
    logic                        at_max;
    logic                        at_min;
    logic                        converged;

    modport master (
        output ae_valid, ae_response, manual_en, manual_index,
        input  dgain_index, dgain_update, at_max, at_min, converged
    );

    modport slave (
        input  ae_valid, ae_response, manual_en, manual_index,
        output dgain_index, dgain_update, at_max, at_min, converged
    );
endinterface

// File: rtl/isp_dgain_ctrl.sv
// Saturating digital-gain index controller driven by per-frame AE verdicts,
// with fine/coarse stepping, convergence detection and manual override.
module isp_dgain_ctrl #(
    parameter int DGAIN_ARRAY_SIZE = 100,
    parameter int DGAIN_ARRAY_BITS = $clog2(DGAIN_ARRAY_SIZE),
    parameter int DGAIN_INIT       = 0,
    parameter int FINE_STEP        = 1,
    parameter int COARSE_STEP      = 4,
    parameter int STREAK_TH        = 3,
    parameter int CONV_CNT         = 4
) (
    input  logic               pclk,
    input  logic               rst_n,
    isp_dgain_ctrl_if.slave    bus
);
    localparam int BITS = DGAIN_ARRAY_BITS;
    localparam int W    = DGAIN_ARRAY_BITS + 1;
    localparam int SW   = $clog2(STREAK_TH + 1);
    localparam int CW   = $clog2(CONV_CNT + 1);

    localparam logic [W-1:0]    MAX_W    = W'(DGAIN_ARRAY_SIZE - 1);
    localparam logic [W-1:0]    FINE_W   = W'(FINE_STEP);
    localparam logic [W-1:0]    COARSE_W = W'(COARSE_STEP);
    localparam logic [SW-1:0]   STREAK_W = SW'(STREAK_TH);
    localparam logic [CW-1:0]   CONV_W   = CW'(CONV_CNT);
    localparam logic [BITS-1:0] MAX_IDX  = BITS'(DGAIN_ARRAY_SIZE - 1);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    logic [BITS-1:0] index_q, index_d;
    logic            update_q, update_d;
    logic            at_max_q, at_max_d;
    logic            at_min_q, at_min_d;
    logic            converged_q, converged_d;
    dir_e            dir_q, dir_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [CW-1:0]   conv_cnt_q, conv_cnt_d;

    dir_e            move_dir;
    logic [W-1:0]    idx_w, step_w, sum_w, new_w, man_w;

    always_comb begin
        index_d     = index_q;
        dir_d       = dir_q;
        streak_d    = streak_q;
        conv_cnt_d  = conv_cnt_q;
        converged_d = converged_q;
        move_dir    = DIR_NONE;
        idx_w       = {1'b0, index_q};
        step_w      = FINE_W;
        sum_w       = '0;
        new_w       = idx_w;
        man_w       = (bus.manual_index > MAX_W) ? MAX_W : bus.manual_index;

        if (bus.manual_en) begin
            // Override owns the index; the verdict this cycle is dropped.
            index_d     = man_w[BITS-1:0];
            dir_d       = DIR_NONE;
            streak_d    = '0;
            conv_cnt_d  = '0;
            converged_d = 1'b0;
        end else if (bus.ae_valid) begin
            case (bus.ae_response)
                2'b01, 2'b10: begin
                    move_dir = (bus.ae_response == 2'b01) ? DIR_UP : DIR_DN;
                    if (move_dir == dir_q && streak_q >= STREAK_W) begin
                        step_w = COARSE_W;
                    end
                    sum_w = idx_w + step_w;
                    if (move_dir == DIR_UP) begin
                        new_w = (sum_w > MAX_W) ? MAX_W : sum_w;
                    end else begin
                        new_w = (idx_w < step_w) ? '0 : idx_w - step_w;
                    end
                    index_d = new_w[BITS-1:0];
                    if (move_dir == dir_q) begin
                        streak_d = (streak_q >= STREAK_W) ? STREAK_W : streak_q + SW'(1);
                    end else begin
                        dir_d    = move_dir;
                        streak_d = SW'(1);
                    end
                    conv_cnt_d  = '0;
                    converged_d = 1'b0;
                end
                2'b00: begin
                    dir_d       = DIR_NONE;
                    streak_d    = '0;
                    conv_cnt_d  = (conv_cnt_q >= CONV_W) ? CONV_W : conv_cnt_q + CW'(1);
                    converged_d = (conv_cnt_d >= CONV_W);
                end
                default: begin
                end
            endcase
        end

        // Flags decode the next index so they land on the same edge as it.
        update_d = (index_d != index_q);
        at_max_d = (index_d == MAX_IDX);
        at_min_d = (index_d == '0);
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            index_q     <= BITS'(DGAIN_INIT);
            update_q    <= 1'b0;
            at_max_q    <= (DGAIN_INIT == DGAIN_ARRAY_SIZE - 1);
            at_min_q    <= (DGAIN_INIT == 0);
            converged_q <= 1'b0;
            dir_q       <= DIR_NONE;
            streak_q    <= '0;
            conv_cnt_q  <= '0;
        end else begin
            index_q     <= index_d;
            update_q    <= update_d;
            at_max_q    <= at_max_d;
            at_min_q    <= at_min_d;
            converged_q <= converged_d;
            dir_q       <= dir_d;
            streak_q    <= streak_d;
            conv_cnt_q  <= conv_cnt_d;
        end
    end

    assign bus.dgain_index  = index_q;
    assign bus.dgain_update = update_q;
    assign bus.at_max       = at_max_q;
    assign bus.at_min       = at_min_q;
    assign bus.converged    = converged_q;
endmodule

// File: tb/tb_isp_dgain_ctrl.sv
// Bench for isp_dgain_ctrl: directed vector table, hand-written reset sequences,
// and randomized verdicts checked against an integer reference model.
module tb_isp_dgain_ctrl;
    localparam int SIZE = 100;
    localparam int BITS = 7;

    logic pclk;
    logic rst_n;

    isp_dgain_ctrl_if #(.DGAIN_ARRAY_BITS(BITS)) bus ();

    isp_dgain_ctrl dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests;
    int n_fail;

    // reference model state
    int m_idx;
    int m_dir;
    int m_streak;
    int m_conv;
    int m_convd;
    int m_upd;

    typedef struct {
        logic       v;
        logic [1:0] r;
        logic       me;
        logic [7:0] mi;
        int         e_idx;
        int         e_upd;
        int         e_conv;
    } vec_t;

    vec_t tbl[26];

    task automatic model_reset();
        m_idx    = 0;
        m_dir    = 0;
        m_streak = 0;
        m_conv   = 0;
        m_convd  = 0;
        m_upd    = 0;
    endtask

    task automatic model_step(input logic v, input logic [1:0] r, input logic me, input int mi);
        int nidx;
        int d;
        int step;
        nidx = m_idx;
        if (me) begin
            nidx     = (mi > SIZE - 1) ? SIZE - 1 : mi;
            m_dir    = 0;
            m_streak = 0;
            m_conv   = 0;
            m_convd  = 0;
        end else if (v && r == 2'b00) begin
            m_dir    = 0;
            m_streak = 0;
            m_conv   = (m_conv + 1 > 4) ? 4 : m_conv + 1;
            m_convd  = (m_conv >= 4) ? 1 : 0;
        end else if (v && r != 2'b11) begin
            d    = (r == 2'b01) ? 1 : -1;
            step = (d == m_dir && m_streak >= 3) ? 4 : 1;
            if (d > 0) nidx = (m_idx + step > SIZE - 1) ? SIZE - 1 : m_idx + step;
            else       nidx = (m_idx < step) ? 0 : m_idx - step;
            m_streak = (d == m_dir) ? ((m_streak + 1 > 3) ? 3 : m_streak + 1) : 1;
            m_dir    = d;
            m_conv   = 0;
            m_convd  = 0;
        end
        m_upd = (nidx != m_idx) ? 1 : 0;
        m_idx = nidx;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e_idx, input int e_upd, input int e_conv);
        chk({tag, ".dgain_index"}, int'(bus.dgain_index), e_idx);
        chk({tag, ".dgain_update"}, int'(bus.dgain_update), e_upd);
        chk({tag, ".converged"}, int'(bus.converged), e_conv);
        chk({tag, ".at_max"}, int'(bus.at_max), (e_idx == SIZE - 1) ? 1 : 0);
        chk({tag, ".at_min"}, int'(bus.at_min), (e_idx == 0) ? 1 : 0);
    endtask

    // driver: apply one cycle of inputs (rst low resets), keep the model in step
    task automatic cycle(input logic rst, input logic v, input logic [1:0] r, input logic me, input logic [7:0] mi);
        rst_n            = rst;
        bus.ae_valid     = v;
        bus.ae_response  = r;
        bus.manual_en    = me;
        bus.manual_index = mi;
        if (!rst) model_reset();
        else      model_step(v, r, me, int'(mi));
        @(posedge pclk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n            = 1'b0;
        bus.ae_valid     = 1'b0;
        bus.ae_response  = 2'b00;
        bus.manual_en    = 1'b0;
        bus.manual_index = '0;
        model_reset();

        // reset held for two edges
        @(posedge pclk);
        @(posedge pclk);
        #1;
        check_out("reset", 0, 0, 0);

        // {v, resp, manual_en, manual_index, idx, update, converged}
        tbl[0]  = '{1'b1, 2'b01, 1'b0, 8'd0,   1,  1, 0};
        tbl[1]  = '{1'b1, 2'b01, 1'b0, 8'd0,   2,  1, 0};
        tbl[2]  = '{1'b1, 2'b01, 1'b0, 8'd0,   3,  1, 0};
        tbl[3]  = '{1'b1, 2'b01, 1'b0, 8'd0,   7,  1, 0};
        tbl[4]  = '{1'b1, 2'b01, 1'b0, 8'd0,   11, 1, 0};
        tbl[5]  = '{1'b1, 2'b10, 1'b0, 8'd0,   10, 1, 0};
        tbl[6]  = '{1'b0, 2'b00, 1'b1, 8'd97,  97, 1, 0};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 8'd0,   98, 1, 0};
        tbl[8]  = '{1'b1, 2'b01, 1'b0, 8'd0,   99, 1, 0};
        tbl[9]  = '{1'b1, 2'b01, 1'b0, 8'd0,   99, 0, 0};
        tbl[10] = '{1'b1, 2'b01, 1'b0, 8'd0,   99, 0, 0};
        tbl[11] = '{1'b0, 2'b00, 1'b1, 8'd1,   1,  1, 0};
        tbl[12] = '{1'b1, 2'b10, 1'b0, 8'd0,   0,  1, 0};
        tbl[13] = '{1'b1, 2'b10, 1'b0, 8'd0,   0,  0, 0};
        tbl[14] = '{1'b1, 2'b10, 1'b0, 8'd0,   0,  0, 0};
        tbl[15] = '{1'b1, 2'b10, 1'b0, 8'd0,   0,  0, 0};
        tbl[16] = '{1'b1, 2'b00, 1'b0, 8'd0,   0,  0, 0};
        tbl[17] = '{1'b1, 2'b00, 1'b0, 8'd0,   0,  0, 0};
        tbl[18] = '{1'b1, 2'b11, 1'b0, 8'd0,   0,  0, 0};
        tbl[19] = '{1'b1, 2'b00, 1'b0, 8'd0,   0,  0, 0};
        tbl[20] = '{1'b1, 2'b00, 1'b0, 8'd0,   0,  0, 1};
        tbl[21] = '{1'b1, 2'b01, 1'b0, 8'd0,   1,  1, 0};
        tbl[22] = '{1'b0, 2'b00, 1'b1, 8'd150, 99, 1, 0};
        tbl[23] = '{1'b1, 2'b01, 1'b1, 8'd150, 99, 0, 0};
        tbl[24] = '{1'b1, 2'b10, 1'b0, 8'd0,   98, 1, 0};
        tbl[25] = '{1'b0, 2'b01, 1'b0, 8'd0,   98, 0, 0};

        for (int i = 0; i < 26; i++) begin
            cycle(1'b1, tbl[i].v, tbl[i].r, tbl[i].me, tbl[i].mi);
            check_out($sformatf("vec%0d", i), tbl[i].e_idx, tbl[i].e_upd, tbl[i].e_conv);
        end

        // reset in the middle of a coarse up-streak at index 40
        cycle(1'b1, 1'b0, 2'b00, 1'b1, 8'd33);
        check_out("mid.load", 33, 1, 0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
        check_out("mid.36", 36, 1, 0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
        check_out("mid.40", 40, 1, 0);
        cycle(1'b0, 1'b1, 2'b01, 1'b0, 8'd0);
        check_out("mid.reset", 0, 0, 0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
        check_out("mid.after", 1, 1, 0);

        // reset while in manual mode with a verdict present
        cycle(1'b0, 1'b1, 2'b01, 1'b1, 8'd60);
        check_out("man.reset", 0, 0, 0);

        // randomized: phase 0 leans upward, phase 1 leans downward
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 400; i++) begin
                logic       rv;
                logic [1:0] rr;
                logic       rme;
                logic [7:0] rmi;
                logic       rrst;
                rv   = ($urandom_range(0, 3) != 0);
                rr   = ($urandom_range(0, 9) < 6) ? ((p == 0) ? 2'b01 : 2'b10) : 2'($urandom_range(0, 3));
                rme  = ($urandom_range(0, 19) == 0);
                rmi  = 8'($urandom_range(0, 255));
                rrst = ($urandom_range(0, 149) != 0);
                cycle(rrst, rv, rr, rme, rmi);
                check_out("rand", m_idx, m_upd, m_convd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/isp_dgain_ctrl.md
# isp_dgain_ctrl

Parametrised digital-gain index controller, successor to `isp_dgain_update`. Consumes the 2-bit auto-exposure (AE) verdict once per frame. Maintains a saturating index into the digital-gain table, with these additions over the previous block:
- adaptive fine/coarse stepping;
- convergence detection;
- manual override;
- saturation flags.

It sits between the AE statistics block and the digital-gain multiplier, in the `pclk` domain.

## Interface
Parameters:
- DGAIN_ARRAY_SIZE, 100, number of gain-table entries; index range 0..SIZE-1.
- DGAIN_ARRAY_BITS, $clog2(DGAIN_ARRAY_SIZE), index width.
- DGAIN_INIT, 0, index loaded at reset; must be ≤ SIZE-1.
- FINE_STEP, 1, step applied normally.
- COARSE_STEP, 4, step applied once a same-direction streak reaches the threshold.
- STREAK_TH, 3, number of prior consecutive same-direction verdicts that enables the coarse step.
- CONV_CNT, 4, number of consecutive "correct" verdicts that declares convergence.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ae_valid  in  1  single-cycle strobe; ae_response is valid this cycle.
- ae_response  in  2  00 = correct, 01 = underexposed (increase), 10 = overexposed (decrease), 11 = invalid.
- manual_en  in  1  1 = manual override, 0 = auto.
- manual_index  in  DGAIN_ARRAY_BITS+1  requested manual index (one extra bit so out-of-range values are testable).
- dgain_index  out  DGAIN_ARRAY_BITS  current gain-table index, registered.
- dgain_update  out  1  one-cycle pulse in the cycle dgain_index takes a changed value.
- at_max  out  1  dgain_index == SIZE-1.
- at_min  out  1  dgain_index == 0.
- converged  out  1  CONV_CNT or more consecutive 00 verdicts since the last move.

## Operation
- Reset (rst_n = 0 at a clock edge) sets:
  - dgain_index = DGAIN_INIT, dgain_update = 0, converged = 0;
  - at_min/at_max decoded from DGAIN_INIT;
  - streak_dir = none, streak_cnt = 0, conv_cnt = 0.
  - Reset takes priority over every other input, including mid-streak or in manual mode.
- Auto mode (manual_en = 0). Each ae_valid = 1 cycle is evaluated as follows:
  - 01 / 10 (move):
    - If the direction equals streak_dir and streak_cnt ≥ STREAK_TH, step = COARSE_STEP; otherwise step = FINE_STEP.
    - Then: if direction == streak_dir, streak_cnt increments, saturating at STREAK_TH. Otherwise streak_dir = new direction and streak_cnt = 1.
    - conv_cnt clears; converged clears.
  - 00:
    - streak_dir = none, streak_cnt = 0.
    - conv_cnt increments, saturating at CONV_CNT; converged = (conv_cnt after increment ≥ CONV_CNT).
    - Index is unchanged.
  - 11: ignored entirely. No state change and no pulse.
  - Cycles with ae_valid = 0 change nothing; gaps do not break a streak.
- Arithmetic is done in DGAIN_ARRAY_BITS+1 bits:
  - increase: new = min(index + step, SIZE-1);
  - decrease: new = (index < step) ? 0 : index - step.
- dgain_update = 1 only if new ≠ old. A saturated, unchanged index gives no pulse, but the streak/conv bookkeeping above still applies.
- Manual mode (manual_en = 1):
  - dgain_index = min(manual_index, SIZE-1) every cycle.
  - dgain_update pulses when the value changes.
  - ae_valid is ignored.
  - streak and conv counters clear; converged = 0.
- Leaving manual mode: auto resumes from the current dgain_index with counters cleared.
- at_max and at_min are decoded from the next-state index and registered, so they are always coherent with dgain_index.

## Timing
- Latency: a verdict sampled on edge N appears on dgain_index, dgain_update, flags and converged after edge N. This is the same edge as the sampling register, one cycle of visible latency.
- dgain_update is a single-cycle pulse. Back-to-back ae_valid gives back-to-back pulses.
- A manual_en transition takes effect on the first edge it is sampled high or low.
- When manual_en and ae_valid are high in the same cycle, manual wins and the verdict is discarded.
- No throughput limit: one verdict per cycle is supported.

## Test plan
All scenarios use the default parameters.
- **Reset:** hold rst_n = 0 for 2 edges, then release -> dgain_index = 0, at_min = 1, at_max = 0, converged = 0, dgain_update = 0.
- **Acceleration:** five ae_valid pulses of 01 from 0 -> index 1, 2, 3, 7, 11, with a dgain_update pulse on each. Then one 10 -> index 10 (fine step; streak restarts at 1).
- **Upper saturation:**
  - Manual-load 97, release manual, then four 01 -> 98, 99 (at_max = 1), 99, 99.
  - Pulses only on the first two.
  - Four 10 from 1 -> 0 (at_min = 1), then no further change.
- **Convergence and invalid code:**
  - Sequence 00, 00, 11, 00 -> converged = 0 (the 11 neither breaks nor advances the count).
  - A further 00 -> converged = 1.
  - Then 01 -> converged = 0 and index +1.
- **Manual override:**
  - manual_index = 150 -> dgain_index = 99 next cycle.
  - manual_en = 1 with simultaneous ae_valid/01 -> index stays 99.
  - Drop manual_en, send 10 -> 98 with a fine step.
- **Reset mid-operation:** during a coarse streak at index 40, assert rst_n = 0 for one edge -> index = DGAIN_INIT (0). The next 01 steps by 1, proving the streak was cleared.
